alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  Execute-stage ALU: consumer of the 3-bit ALU Operation code produced by ALU control.
//  Computes result and memory/writeback controls for Load/Store/Add/Not/Nop.
//  Registers them toward the EX/MEM stage through a 2-entry skid buffer with valid/ready on both sides.
//  Latency 1 cycle; full throughput when downstream is ready.
// PARAMETERS
//  WIDTH     16  datapath width of SrcA, SrcB, Result, StoreData
//  RD_W       3  register-file address width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  InValid    in   1        upstream beat valid
//  InReady    out  1        stage can accept a beat (registered)
//  Operation  in   3        001 Load, 010 Store, 011 Add, 100 Not, 101 Nop
//  SrcA       in   WIDTH    operand A / memory address
//  SrcB       in   WIDTH    operand B / store data
//  RdIn       in   RD_W     destination register
//  OutValid   out  1        output beat valid
//  OutReady   in   1        downstream accepts beat
//  Result     out  WIDTH    ALU result or memory address
//  StoreData  out  WIDTH    data for Store
//  RdOut      out  RD_W     destination register
//  RegWrite   out  1        writeback enable
//  MemRead    out  1        memory read enable
//  MemWrite   out  1        memory write enable
//  IllegalOp  out  1        beat carried an undefined code (000/110/111)
//  Flags      out  3        {C,N,Z} condition-code register
// BEHAVIOUR
//  Reset (rst=1 at edge): both skid entries empty; OutValid=0, InReady=1, all data/control outs 0, Flags=0.
//  Accept when InValid&&InReady; transfer out when OutValid&&OutReady; both may happen same cycle.
//  InReady = !(entry1 valid) (registered); a beat accepted while the output is stalled goes to entry1.
//  Order strictly preserved; simultaneous accept+drain with entry1 full: entry1->entry0, new beat->entry1.
//  Full (2 entries) -> InReady=0 next cycle; InValid ignored while InReady=0.
//  Output regs hold stable while OutValid&&!OutReady.
//  Load : Result=SrcA, MemRead=1, RegWrite=1.   Store: Result=SrcA, StoreData=SrcB, MemWrite=1.
//  Add  : Result=(SrcA+SrcB) mod 2^WIDTH, carry-out to C, RegWrite=1.
//  Not  : Result=~SrcA, RegWrite=1.   Nop: Result=0, all enables 0, still occupies a slot.
//  Undefined codes: handled as Nop, IllegalOp=1 on that beat only.
//  StoreData=0 for non-Store beats; unused control bits always 0.
//  rst mid-operation: both entries discarded in same edge, no partial beat emitted.
// CONFIGURATION
//  ALU_FLAGS_EN defined: Flags updated at accept time (program order):
//    Add -> Z=(Result==0), N=Result[WIDTH-1], C=carry; Not -> Z,N updated, C held; others hold.
//  ALU_FLAGS_EN undefined: no flag registers, Flags tied to 3'b000.
// STRUCTURE
//  Package alu_pkg: OP_LOAD..OP_NOP localparams, FLAG_Z/N/C bit indices, beat struct
//    {Result,StoreData,Rd,RegWrite,MemRead,MemWrite,IllegalOp}.
//  Sub-module alu_skid_buf: generic 2-entry valid/ready buffer of the packed beat; ALU logic stays in top.
// TESTING
//  Add 16'hFFFF+16'h0001, OutReady=1 -> next cycle Result=0, RegWrite=1; FLAGS_EN: Flags=3'b101.
//  Store SrcA=16'h0040,SrcB=16'hBEEF -> Result=16'h0040, StoreData=16'hBEEF, MemWrite=1, RegWrite=0.
//  OutReady=0, push 3 back-to-back beats -> InReady falls after 2nd; 3rd stalls; drain in order.
//  Operation=3'b111 -> Nop beat with IllegalOp=1, all enables 0, Flags unchanged.
//  Assert rst with 2 entries full -> next cycle OutValid=0, InReady=1, Flags=0.
//  Streaming 8 Not beats with OutReady=1 -> 8 outputs on consecutive cycles, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and the packed beat carried from EX toward EX/MEM
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 3;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0] rd;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic illegal_op;
  } beat_t;
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry valid/ready buffer; entry0 drives the output, entry1 absorbs a beat during a stall
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         v0, v1;
  logic [W-1:0] d0, d1;
  logic         acc, drn;
  assign in_ready = !v1;
  assign acc = in_valid && in_ready;
  assign drn = v0 && out_ready;
  assign out_valid = v0;
  assign out_data = d0;
  // entry0 refills from entry1 first to keep order, otherwise from the input; a stalled accept lands in entry1
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else if (!v0 || drn) begin
      v0 <= v1 || acc;
      v1 <= 1'b0;
      if (v1) d0 <= d1;
      else if (acc) d0 <= in_data;
    end else if (acc) begin
      v1 <= 1'b1;
      d1 <= in_data;
    end
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU feeding EX/MEM through a skid buffer; ALU_FLAGS_EN enables the {C,N,Z} register
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int RD_W = REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [RD_W-1:0]  RdIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] StoreData,
  output logic [RD_W-1:0]  RdOut,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IllegalOp,
  output logic [2:0]       Flags
);
  beat_t b, ob;
  logic  acc;
  assign acc = InValid && InReady;
  // decode the operation into a beat; undefined codes fall through to an all-zero Nop with IllegalOp set
  always_comb begin
    b = '0;
    b.result = (Operation == OP_LOAD || Operation == OP_STORE) ? SrcA :
               (Operation == OP_ADD) ? SrcA + SrcB :
               (Operation == OP_NOT) ? ~SrcA : '0;
    b.store_data = (Operation == OP_STORE) ? SrcB : '0;
    b.rd = RdIn;
    b.reg_write = Operation == OP_LOAD || Operation == OP_ADD || Operation == OP_NOT;
    b.mem_read = Operation == OP_LOAD;
    b.mem_write = Operation == OP_STORE;
    b.illegal_op = !(Operation inside {OP_LOAD, OP_STORE, OP_ADD, OP_NOT, OP_NOP});
  end
  alu_skid_buf #(.W($bits(beat_t))) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(InValid),
    .in_ready(InReady),
    .in_data(b),
    .out_valid(OutValid),
    .out_ready(OutReady),
    .out_data(ob)
  );
  assign Result = ob.result;
  assign StoreData = ob.store_data;
  assign RdOut = ob.rd;
  assign RegWrite = ob.reg_write;
  assign MemRead = ob.mem_read;
  assign MemWrite = ob.mem_write;
  assign IllegalOp = ob.illegal_op;
`ifdef ALU_FLAGS_EN
  logic [2:0] flags_q;
  logic       carry;
  assign carry = (SrcA + SrcB) < SrcA;
  assign Flags = flags_q;
  // flags follow program order by updating when a beat is accepted, not when it leaves
  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else if (acc && (Operation == OP_ADD || Operation == OP_NOT)) begin
      flags_q[FLAG_Z] <= b.result == '0;
      flags_q[FLAG_N] <= b.result[WIDTH-1];
      if (Operation == OP_ADD) flags_q[FLAG_C] <= carry;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = acc;
  assign Flags = 3'b000;
`endif
endmodule
